// File: rtl/if_id_fifo_pkg.sv
// Shared defaults and types for the IF->ID instruction queue.
// Included by the queue top and its pointer sub-module.
package if_id_fifo_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 32;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam logic [31:0] DEF_NOP        = 32'h0000_0013;

   // Encoding is {pop, push} so the op can be built straight from the handshake bits
   typedef enum logic [1:0] {
      Q_IDLE = 2'b00,
      Q_PUSH = 2'b01,
      Q_POP  = 2'b10,
      Q_BOTH = 2'b11
   } q_op_e;

endpackage

// File: rtl/if_id_fifo_ptr.sv
// Wrap-around queue pointer with increment and synchronous clear.
// Wrap comes for free because the queue depth is a power of two.
module if_id_fifo_ptr #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] ptr_o
);

   logic [WIDTH-1:0] ptr_q;
   logic [WIDTH-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = ptr_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/if_id_fifo.sv
// IF->ID decoupling queue: DEPTH-entry instruction FIFO with valid/ready
// handshake, single-cycle flush, and a NOP bubble presented when empty.
module if_id_fifo
   import if_id_fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(DEF_NOP)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    inst_valid_i,
   input  logic [ADDR_WIDTH-1:0]   inst_addr_i,
   input  logic [DATA_WIDTH-1:0]   inst_i,
   output logic                    inst_ready_o,
   output logic                    inst_valid_o,
   output logic [ADDR_WIDTH-1:0]   inst_addr_o,
   output logic [DATA_WIDTH-1:0]   inst_o,
   input  logic                    stall_i,
   input  logic                    flush_i,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] inst;
   } entry_t;

   entry_t           storage_q [DEPTH];
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             push;
   logic             pop;
   q_op_e            op;

   // Handshake depends only on registered occupancy, never on this cycle's inputs
   assign inst_ready_o = (count_q < DEPTH_C);
   assign inst_valid_o = (count_q != '0);

   assign push = inst_valid_i & inst_ready_o & ~flush_i;
   assign pop  = inst_valid_o & ~stall_i & ~flush_i;
   assign op   = q_op_e'({pop, push});

   always_comb begin
      count_d = count_q;
      if (flush_i) begin
         count_d = '0;
      end else begin
         unique case (op)
            Q_PUSH:  count_d = count_q + CNT_W'(1);
            Q_POP:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Payload storage carries no reset; the empty mux hides stale contents
   always_ff @(posedge clk_i) begin
      if (push) begin
         storage_q[wr_ptr] <= '{addr: inst_addr_i, inst: inst_i};
      end
   end

   if_id_fifo_ptr #(.WIDTH(PTR_W)) u_wr_ptr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (push),
      .clr_i (flush_i),
      .ptr_o (wr_ptr)
   );

   if_id_fifo_ptr #(.WIDTH(PTR_W)) u_rd_ptr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (pop),
      .clr_i (flush_i),
      .ptr_o (rd_ptr)
   );

   assign head        = storage_q[rd_ptr];
   assign inst_o      = inst_valid_o ? head.inst : NOP_INST;
   assign inst_addr_o = inst_valid_o ? head.addr : '0;
   assign count_o     = count_q;

endmodule

// File: tb/tb_if_id_fifo.sv
// Bench for the IF->ID instruction queue: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_if_id_fifo;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } ent_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        inst_valid_i;
   logic [31:0] inst_addr_i;
   logic [31:0] inst_i;
   logic        inst_ready_o;
   logic        inst_valid_o;
   logic [31:0] inst_addr_o;
   logic [31:0] inst_o;
   logic        stall_i;
   logic        flush_i;
   logic [2:0]  count_o;

   int   n_tests = 0;
   int   n_fail  = 0;
   ent_t model_q[$];

   always #5 clk_i = ~clk_i;

   if_id_fifo #(.DEPTH(DEPTH)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .inst_valid_i (inst_valid_i),
      .inst_addr_i  (inst_addr_i),
      .inst_i       (inst_i),
      .inst_ready_o (inst_ready_o),
      .inst_valid_o (inst_valid_o),
      .inst_addr_o  (inst_addr_o),
      .inst_o       (inst_o),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .count_o      (count_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int unsigned n;
      n = model_q.size();
      chk({tag, ".valid"}, 64'(inst_valid_o), 64'(n != 0));
      chk({tag, ".ready"}, 64'(inst_ready_o), 64'(n < DEPTH));
      chk({tag, ".count"}, 64'(count_o),      64'(n));
      chk({tag, ".inst"},  64'(inst_o),       64'((n != 0) ? model_q[0].inst : NOP));
      chk({tag, ".addr"},  64'(inst_addr_o),  64'((n != 0) ? model_q[0].addr : 32'h0));
   endtask

   // One clock of the reference: flush wins, otherwise pop then push,
   // both judged against occupancy before the edge.
   function automatic void model_edge(input logic v, input logic [31:0] a,
                                      input logic [31:0] d, input logic st,
                                      input logic fl);
      bit can_push;
      bit can_pop;
      can_push = v && (model_q.size() < DEPTH);
      can_pop  = !st && (model_q.size() != 0);
      if (fl) begin
         model_q.delete();
      end else begin
         if (can_pop) void'(model_q.pop_front());
         if (can_push) model_q.push_back('{addr: a, inst: d});
      end
   endfunction

   task automatic step(input string tag, input logic v, input logic [31:0] a,
                       input logic st, input logic fl);
      logic [31:0] d;
      d = $urandom;
      inst_valid_i = v;
      inst_addr_i  = a;
      inst_i       = d;
      stall_i      = st;
      flush_i      = fl;
      @(posedge clk_i);
      model_edge(v, a, d, st, fl);
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_i        = 1'b1;
      inst_valid_i = 1'b0;
      inst_addr_i  = '0;
      inst_i       = '0;
      stall_i      = 1'b0;
      flush_i      = 1'b0;

      // Reset and idle
      repeat (2) @(posedge clk_i);
      #1;
      check_all("reset");
      #2 rst_i = 1'b0;
      step("idle", 1'b0, 32'h0, 1'b0, 1'b0);

      // Back-to-back pushes with no stall: each visible one cycle later
      step("stream", 1'b1, 32'h0, 1'b0, 1'b0);
      step("stream", 1'b1, 32'h4, 1'b0, 1'b0);
      step("stream", 1'b1, 32'h8, 1'b0, 1'b0);
      step("stream", 1'b0, 32'h0, 1'b0, 1'b0);
      chk("stream_drained", 64'(count_o), 64'd0);

      // Fill under stall; fifth entry is held by fetch
      for (int i = 0; i < 5; i++) step("fill", 1'b1, 32'(i * 4), 1'b1, 1'b0);
      chk("fill_ready_low", 64'(inst_ready_o), 64'd0);
      chk("fill_head", 64'(inst_addr_o), 64'h0);
      step("release", 1'b1, 32'h10, 1'b0, 1'b0);
      step("release", 1'b1, 32'h10, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("drain", 1'b0, 32'h0, 1'b0, 1'b0);

      // Flush beats stall and a same-cycle push
      for (int i = 0; i < 3; i++) step("pre_flush", 1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
      step("flush", 1'b1, 32'h200, 1'b1, 1'b1);
      chk("flush_inst", 64'(inst_o), 64'(NOP));
      step("post_flush", 1'b1, 32'h300, 1'b1, 1'b0);
      step("post_flush", 1'b0, 32'h0, 1'b0, 1'b0);
      step("post_flush", 1'b0, 32'h0, 1'b0, 1'b0);

      // Full queue with a pop: no push that cycle, ready back next cycle
      for (int i = 0; i < 4; i++) step("full", 1'b1, 32'h400 + 32'(i * 4), 1'b1, 1'b0);
      step("full_pop", 1'b1, 32'h500, 1'b0, 1'b0);
      chk("full_pop_count", 64'(count_o), 64'd3);
      step("full_pop2", 1'b1, 32'h500, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("drain2", 1'b0, 32'h0, 1'b0, 1'b0);

      // Pointer wrap under continuous push/pop
      for (int i = 0; i < 20; i++) step("wrap", 1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
      step("wrap_end", 1'b0, 32'h0, 1'b0, 1'b0);

      // Asynchronous reset mid-stream with two entries queued
      step("pre_rst", 1'b1, 32'h2000, 1'b1, 1'b0);
      step("pre_rst", 1'b1, 32'h2004, 1'b1, 1'b0);
      inst_valid_i = 1'b0;
      #2 rst_i = 1'b1;
      #1;
      model_q.delete();
      check_all("async_rst");
      #1 rst_i = 1'b0;
      step("post_rst", 1'b1, 32'h3000, 1'b0, 1'b0);
      step("post_rst", 1'b0, 32'h0, 1'b0, 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step("rand",
              1'(($urandom % 10) < 7),
              32'($urandom),
              1'(($urandom % 10) < 3),
              1'(($urandom % 20) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
